// File: rtl/bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bank_rr_arbiter
//   Per-bank arbiter placed in front of one memory bank. A core is eligible
//   when its request is valid and its address bank field selects this bank.
//   The grant is registered and held until the bank signals completion, the
//   grantee stops requesting, or the watchdog expires. The next grantee is
//   then picked in the same cycle, round robin with wrap-around or fixed
//   priority (lowest index), so back-to-back handovers have no bubble.
//
// Ports
//   clock        : system clock
//   reset        : synchronous, active-high reset
//   bank_num     : bank served by this instance (static)
//   rr_en        : 1 = round robin, 0 = fixed priority (lowest index)
//   core_val     : per-core request valid
//   core_addr    : per-core address, core i at [i*ADDR_W +: ADDR_W]
//   core_done    : 1-cycle pulse, bank finished the grantee's transaction
//   grant_vld    : a grant is held
//   grant_core   : index of the granted core
//   grant_onehot : one-hot grant, all zeros when grant_vld=0
//   timeout_err  : 1-cycle pulse when the watchdog forces a release
// ---------------------------------------------------------------------------
module bank_rr_arbiter #(
  parameter int NUM_CORES = 16,
  parameter int CORE_W    = 4,
  parameter int ADDR_W    = 12,
  parameter int BANK_LSB  = 8,
  parameter int BANK_W    = 4,
  parameter int TIMEOUT   = 64,
  parameter int TMO_W     = 7
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [BANK_W-1:0]           bank_num,
  input  logic                        rr_en,
  input  logic [NUM_CORES-1:0]        core_val,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic                        core_done,
  output logic                        grant_vld,
  output logic [CORE_W-1:0]           grant_core,
  output logic [NUM_CORES-1:0]        grant_onehot,
  output logic                        timeout_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Timer value on which the watchdog fires (unused when TIMEOUT == 0).
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : TMO_W'(TIMEOUT - 1);

  state_t                 r_state;
  logic                   r_grant_vld;
  logic [CORE_W-1:0]      r_grant_core;
  logic [NUM_CORES-1:0]   r_grant_onehot;
  logic                   r_timeout_err;
  logic [CORE_W-1:0]      r_last;
  logic [TMO_W-1:0]       r_timer;

  logic [NUM_CORES-1:0]   w_eligible;
  logic                   w_found;
  logic [CORE_W-1:0]      w_winner;
  logic [CORE_W-1:0]      w_idx;
  logic                   w_timeout;
  logic                   w_release;
  logic                   w_search;
  logic                   w_unused;

  // Only the bank field of each address matters here.
  assign w_unused = ^core_addr;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_elig
      assign w_eligible[gi] = core_val[gi] &&
                              (core_addr[gi*ADDR_W+BANK_LSB +: BANK_W] == bank_num);
    end
  endgenerate

  // Winner search. Loops run from the lowest-priority candidate to the
  // highest so that the last hit (highest priority) is the one kept.
  // In round robin the candidate order is last+1 ... last+NUM_CORES, so the
  // previous grantee itself is considered last.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    if (rr_en) begin
      for (int k = NUM_CORES; k >= 1; k--) begin
        w_idx = CORE_W'((int'(r_last) + k) % NUM_CORES);
        if (w_eligible[w_idx]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end else begin
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
        w_idx = CORE_W'(i);
        if (w_eligible[w_idx]) begin
          w_found  = 1'b1;
          w_winner = w_idx;
        end
      end
    end
  end

  assign w_timeout = (TIMEOUT != 0) && (r_timer == TMO_LAST);
  assign w_release = core_done || !w_eligible[r_grant_core] || w_timeout;
  // A new search is made from IDLE every cycle, and from BUSY on release.
  assign w_search  = (r_state == ST_IDLE) || w_release;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_grant_vld    <= 1'b0;
      r_grant_core   <= '0;
      r_grant_onehot <= '0;
      r_timeout_err  <= 1'b0;
      r_timer        <= '0;
      r_last         <= CORE_W'(NUM_CORES - 1);
    end else begin
      // core_done on the timeout cycle is a normal completion, not an error.
      r_timeout_err <= (r_state == ST_BUSY) && w_timeout && !core_done;
      if (w_search) begin
        r_timer <= '0;
        if (w_found) begin
          r_state        <= ST_BUSY;
          r_grant_vld    <= 1'b1;
          r_grant_core   <= w_winner;
          r_grant_onehot <= {{(NUM_CORES-1){1'b0}}, 1'b1} << w_winner;
          r_last         <= w_winner;
        end else begin
          r_state        <= ST_IDLE;
          r_grant_vld    <= 1'b0;
          r_grant_core   <= '0;
          r_grant_onehot <= '0;
        end
      end else begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign grant_vld    = r_grant_vld;
  assign grant_core   = r_grant_core;
  assign grant_onehot = r_grant_onehot;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_bank_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bank_rr_arbiter
//   Self-checking bench for bank_rr_arbiter (TIMEOUT=8, bank_num=2). Each
//   scenario task builds a step table; per step the inputs are driven on the
//   falling edge, the expected outputs are pushed to a scoreboard queue, and
//   after the next rising edge the entry is popped and compared.
// ---------------------------------------------------------------------------
module tb_bank_rr_arbiter;

  localparam int NC = 16;
  localparam int AW = 12;

  logic           clock;
  logic           reset;
  logic [3:0]     bank_num;
  logic           rr_en;
  logic [NC-1:0]  core_val;
  logic [NC*AW-1:0] core_addr;
  logic           core_done;
  logic           grant_vld;
  logic [3:0]     grant_core;
  logic [NC-1:0]  grant_onehot;
  logic           timeout_err;

  // Cores whose bit is set here address bank 3, all others bank 2.
  logic [NC-1:0]  alt_mask;

  typedef struct {
    logic [NC-1:0] val;
    logic [NC-1:0] alt;
    logic          done;
    logic          rr;
    logic          rst;
    logic          vld;
    logic [3:0]    core;
    logic          tmo;
  } step_t;

  typedef struct {
    logic       vld;
    logic [3:0] core;
    logic       tmo;
    logic       rst;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  bank_rr_arbiter #(
    .NUM_CORES(16), .CORE_W(4), .ADDR_W(12), .BANK_LSB(8),
    .BANK_W(4), .TIMEOUT(8), .TMO_W(7)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bank_num    (bank_num),
    .rr_en       (rr_en),
    .core_val    (core_val),
    .core_addr   (core_addr),
    .core_done   (core_done),
    .grant_vld   (grant_vld),
    .grant_core  (grant_core),
    .grant_onehot(grant_onehot),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    core_addr = '0;
    for (int i = 0; i < NC; i++) begin
      core_addr[i*AW +: AW] = {(alt_mask[i] ? 4'd3 : 4'd2), 8'(i * 13 + 5)};
    end
  end

  function automatic step_t mk(logic [NC-1:0] val, logic [NC-1:0] alt, logic done,
                               logic rr, logic rst, logic vld, logic [3:0] core,
                               logic tmo);
    step_t s;
    s.val = val; s.alt = alt; s.done = done; s.rr = rr; s.rst = rst;
    s.vld = vld; s.core = core; s.tmo = tmo;
    return s;
  endfunction

  task automatic test_reset();
    step_t steps[$];
    exp_t  e;
    logic [NC-1:0] exp_oh;
    steps.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
    // core_done while idle must be ignored
    steps.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    steps.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (steps[k]) begin
      core_val = steps[k].val; alt_mask = steps[k].alt; core_done = steps[k].done;
      rr_en = steps[k].rr; reset = steps[k].rst;
      sb_q.push_back('{vld: steps[k].vld, core: steps[k].core, tmo: steps[k].tmo, rst: steps[k].rst});
      @(posedge clock); @(negedge clock);
      e = sb_q.pop_front();
      exp_oh = e.vld ? (16'd1 << e.core) : 16'd0;
      $display("reset step %0d: vld=%0b core=%0d oh=%h tmo=%0b", k, grant_vld, grant_core, grant_onehot, timeout_err);
      checks++;
      if (grant_vld !== e.vld) begin failures++; $display("FAIL reset_vld step %0d: got %0b expected %0b", k, grant_vld, e.vld); end
      if (e.vld || e.rst) begin
        checks++;
        if (grant_core !== e.core) begin failures++; $display("FAIL reset_core step %0d: got %0d expected %0d", k, grant_core, e.core); end
      end
      checks++;
      if (grant_onehot !== exp_oh) begin failures++; $display("FAIL reset_onehot step %0d: got %h expected %h", k, grant_onehot, exp_oh); end
      checks++;
      if (timeout_err !== e.tmo) begin failures++; $display("FAIL reset_tmo step %0d: got %0b expected %0b", k, timeout_err, e.tmo); end
    end
  endtask

  task automatic test_round_robin();
    step_t steps[$];
    exp_t  e;
    logic [NC-1:0] exp_oh;
    int ord[5] = '{3, 7, 12, 3, 7};
    for (int k = 0; k < 16; k++)
      steps.push_back(mk(16'h1088, 16'h0000, (k % 4) == 3, 1'b1, 1'b0, 1'b1, 4'(ord[(k + 1) / 4]), 1'b0));
    steps.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (steps[k]) begin
      core_val = steps[k].val; alt_mask = steps[k].alt; core_done = steps[k].done;
      rr_en = steps[k].rr; reset = steps[k].rst;
      sb_q.push_back('{vld: steps[k].vld, core: steps[k].core, tmo: steps[k].tmo, rst: steps[k].rst});
      @(posedge clock); @(negedge clock);
      e = sb_q.pop_front();
      exp_oh = e.vld ? (16'd1 << e.core) : 16'd0;
      $display("rr step %0d: vld=%0b core=%0d oh=%h tmo=%0b", k, grant_vld, grant_core, grant_onehot, timeout_err);
      checks++;
      if (grant_vld !== e.vld) begin failures++; $display("FAIL rr_vld step %0d: got %0b expected %0b", k, grant_vld, e.vld); end
      if (e.vld) begin
        checks++;
        if (grant_core !== e.core) begin failures++; $display("FAIL rr_core step %0d: got %0d expected %0d", k, grant_core, e.core); end
      end
      checks++;
      if (grant_onehot !== exp_oh) begin failures++; $display("FAIL rr_onehot step %0d: got %h expected %h", k, grant_onehot, exp_oh); end
      checks++;
      if (timeout_err !== e.tmo) begin failures++; $display("FAIL rr_tmo step %0d: got %0b expected %0b", k, timeout_err, e.tmo); end
    end
  endtask

  task automatic test_wrap();
    step_t steps[$];
    exp_t  e;
    logic [NC-1:0] exp_oh;
    steps.push_back(mk(16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0));
    steps.push_back(mk(16'h8002, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0));
    steps.push_back(mk(16'h8002, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd1,  1'b0));
    steps.push_back(mk(16'h8000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0));
    steps.push_back(mk(16'h8000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd15, 1'b0));
    steps.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0));
    foreach (steps[k]) begin
      core_val = steps[k].val; alt_mask = steps[k].alt; core_done = steps[k].done;
      rr_en = steps[k].rr; reset = steps[k].rst;
      sb_q.push_back('{vld: steps[k].vld, core: steps[k].core, tmo: steps[k].tmo, rst: steps[k].rst});
      @(posedge clock); @(negedge clock);
      e = sb_q.pop_front();
      exp_oh = e.vld ? (16'd1 << e.core) : 16'd0;
      $display("wrap step %0d: vld=%0b core=%0d oh=%h tmo=%0b", k, grant_vld, grant_core, grant_onehot, timeout_err);
      checks++;
      if (grant_vld !== e.vld) begin failures++; $display("FAIL wrap_vld step %0d: got %0b expected %0b", k, grant_vld, e.vld); end
      if (e.vld) begin
        checks++;
        if (grant_core !== e.core) begin failures++; $display("FAIL wrap_core step %0d: got %0d expected %0d", k, grant_core, e.core); end
      end
      checks++;
      if (grant_onehot !== exp_oh) begin failures++; $display("FAIL wrap_onehot step %0d: got %h expected %h", k, grant_onehot, exp_oh); end
      checks++;
      if (timeout_err !== e.tmo) begin failures++; $display("FAIL wrap_tmo step %0d: got %0b expected %0b", k, timeout_err, e.tmo); end
    end
  endtask

  task automatic test_bank_filter();
    step_t steps[$];
    exp_t  e;
    logic [NC-1:0] exp_oh;
    // core 5 targets bank 3, core 6 bank 2; then core 6 moves to bank 3
    steps.push_back(mk(16'h0060, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0));
    steps.push_back(mk(16'h0060, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0));
    steps.push_back(mk(16'h0060, 16'h0060, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    steps.push_back(mk(16'h0060, 16'h0060, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    steps.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (steps[k]) begin
      core_val = steps[k].val; alt_mask = steps[k].alt; core_done = steps[k].done;
      rr_en = steps[k].rr; reset = steps[k].rst;
      sb_q.push_back('{vld: steps[k].vld, core: steps[k].core, tmo: steps[k].tmo, rst: steps[k].rst});
      @(posedge clock); @(negedge clock);
      e = sb_q.pop_front();
      exp_oh = e.vld ? (16'd1 << e.core) : 16'd0;
      $display("bank step %0d: vld=%0b core=%0d oh=%h tmo=%0b", k, grant_vld, grant_core, grant_onehot, timeout_err);
      checks++;
      if (grant_vld !== e.vld) begin failures++; $display("FAIL bank_vld step %0d: got %0b expected %0b", k, grant_vld, e.vld); end
      if (e.vld) begin
        checks++;
        if (grant_core !== e.core) begin failures++; $display("FAIL bank_core step %0d: got %0d expected %0d", k, grant_core, e.core); end
      end
      checks++;
      if (grant_onehot !== exp_oh) begin failures++; $display("FAIL bank_onehot step %0d: got %h expected %h", k, grant_onehot, exp_oh); end
      checks++;
      if (timeout_err !== e.tmo) begin failures++; $display("FAIL bank_tmo step %0d: got %0b expected %0b", k, timeout_err, e.tmo); end
    end
  endtask

  task automatic test_fixed_priority();
    step_t steps[$];
    exp_t  e;
    logic [NC-1:0] exp_oh;
    steps.push_back(mk(16'h0204, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0));
    for (int k = 0; k < 3; k++)
      steps.push_back(mk(16'h0204, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 1'b0));
    steps.push_back(mk(16'h0204, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 1'b0));
    steps.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (steps[k]) begin
      core_val = steps[k].val; alt_mask = steps[k].alt; core_done = steps[k].done;
      rr_en = steps[k].rr; reset = steps[k].rst;
      sb_q.push_back('{vld: steps[k].vld, core: steps[k].core, tmo: steps[k].tmo, rst: steps[k].rst});
      @(posedge clock); @(negedge clock);
      e = sb_q.pop_front();
      exp_oh = e.vld ? (16'd1 << e.core) : 16'd0;
      $display("fixed step %0d: vld=%0b core=%0d oh=%h tmo=%0b", k, grant_vld, grant_core, grant_onehot, timeout_err);
      checks++;
      if (grant_vld !== e.vld) begin failures++; $display("FAIL fixed_vld step %0d: got %0b expected %0b", k, grant_vld, e.vld); end
      if (e.vld) begin
        checks++;
        if (grant_core !== e.core) begin failures++; $display("FAIL fixed_core step %0d: got %0d expected %0d", k, grant_core, e.core); end
      end
      checks++;
      if (grant_onehot !== exp_oh) begin failures++; $display("FAIL fixed_onehot step %0d: got %h expected %h", k, grant_onehot, exp_oh); end
      checks++;
      if (timeout_err !== e.tmo) begin failures++; $display("FAIL fixed_tmo step %0d: got %0b expected %0b", k, timeout_err, e.tmo); end
    end
  endtask

  task automatic test_timeout();
    step_t steps[$];
    exp_t  e;
    logic [NC-1:0] exp_oh;
    // core 4 held 8 cycles, watchdog hands over to core 6 with a pulse
    for (int k = 0; k < 8; k++)
      steps.push_back(mk(16'h0050, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0));
    steps.push_back(mk(16'h0050, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b1));
    for (int k = 0; k < 7; k++)
      steps.push_back(mk(16'h0050, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd6, 1'b0));
    // core_done on the timeout cycle: normal handover, no error pulse
    steps.push_back(mk(16'h0050, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0));
    steps.push_back(mk(16'h0050, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0));
    foreach (steps[k]) begin
      core_val = steps[k].val; alt_mask = steps[k].alt; core_done = steps[k].done;
      rr_en = steps[k].rr; reset = steps[k].rst;
      sb_q.push_back('{vld: steps[k].vld, core: steps[k].core, tmo: steps[k].tmo, rst: steps[k].rst});
      @(posedge clock); @(negedge clock);
      e = sb_q.pop_front();
      exp_oh = e.vld ? (16'd1 << e.core) : 16'd0;
      $display("timeout step %0d: vld=%0b core=%0d oh=%h tmo=%0b", k, grant_vld, grant_core, grant_onehot, timeout_err);
      checks++;
      if (grant_vld !== e.vld) begin failures++; $display("FAIL tmo_vld step %0d: got %0b expected %0b", k, grant_vld, e.vld); end
      if (e.vld) begin
        checks++;
        if (grant_core !== e.core) begin failures++; $display("FAIL tmo_core step %0d: got %0d expected %0d", k, grant_core, e.core); end
      end
      checks++;
      if (grant_onehot !== exp_oh) begin failures++; $display("FAIL tmo_onehot step %0d: got %h expected %h", k, grant_onehot, exp_oh); end
      checks++;
      if (timeout_err !== e.tmo) begin failures++; $display("FAIL tmo_err step %0d: got %0b expected %0b", k, timeout_err, e.tmo); end
    end
  endtask

  task automatic test_reset_mid();
    step_t steps[$];
    exp_t  e;
    logic [NC-1:0] exp_oh;
    steps.push_back(mk(16'h0280, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0));
    steps.push_back(mk(16'h0280, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0));
    steps.push_back(mk(16'h0280, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0));
    steps.push_back(mk(16'h0280, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 1'b0));
    steps.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0));
    foreach (steps[k]) begin
      core_val = steps[k].val; alt_mask = steps[k].alt; core_done = steps[k].done;
      rr_en = steps[k].rr; reset = steps[k].rst;
      sb_q.push_back('{vld: steps[k].vld, core: steps[k].core, tmo: steps[k].tmo, rst: steps[k].rst});
      @(posedge clock); @(negedge clock);
      e = sb_q.pop_front();
      exp_oh = e.vld ? (16'd1 << e.core) : 16'd0;
      $display("rstmid step %0d: vld=%0b core=%0d oh=%h tmo=%0b", k, grant_vld, grant_core, grant_onehot, timeout_err);
      checks++;
      if (grant_vld !== e.vld) begin failures++; $display("FAIL rstmid_vld step %0d: got %0b expected %0b", k, grant_vld, e.vld); end
      if (e.vld || e.rst) begin
        checks++;
        if (grant_core !== e.core) begin failures++; $display("FAIL rstmid_core step %0d: got %0d expected %0d", k, grant_core, e.core); end
      end
      checks++;
      if (grant_onehot !== exp_oh) begin failures++; $display("FAIL rstmid_onehot step %0d: got %h expected %h", k, grant_onehot, exp_oh); end
      checks++;
      if (timeout_err !== e.tmo) begin failures++; $display("FAIL rstmid_tmo step %0d: got %0b expected %0b", k, timeout_err, e.tmo); end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bank_num  = 4'd2;
    rr_en     = 1'b1;
    core_val  = '0;
    alt_mask  = '0;
    core_done = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    test_reset();
    test_round_robin();
    test_wrap();
    test_bank_filter();
    test_fixed_priority();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "bench time limit reached");
  end

endmodule
